// File: rtl/collatz_responder_pkg.sv
// ---------------------------------------------------------------------------
// collatz_responder_pkg
//   Shared definitions for the Collatz responder slice.
//   Contents:
//     COLLATZ_N_DEFAULT - default data / step-count width in bits
//     state_t           - responder FSM encodings (IDLE, RUN, DONE)
//     ALL_ONES_WIDE     - all-ones constant; modules take the low N bits of
//                         it as the saturated "invalid result" code
//                         (so N must not exceed 64)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package collatz_responder_pkg;

  localparam int COLLATZ_N_DEFAULT = 27;

  localparam logic [63:0] ALL_ONES_WIDE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/collatz_responder_step.sv
// ---------------------------------------------------------------------------
// collatz_step
//   Purely combinational single Collatz update for one value.
//   Ports:
//     value      in  N  current value (caller guarantees value > 1)
//     next_value out N  value after this update
//     count_inc  out 2  steps this update represents (1, or 2 with shortcut)
//     ovf        out 1  3*value+1 does not fit in N bits
//   Configuration macro: COLLATZ_SHORTCUT_EN
//     defined   - odd update folds the following halving in: (3v+1)>>1, +2
//     undefined - plain update: 3v+1, +1
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module collatz_step
  import collatz_responder_pkg::*;
#(
  parameter int N = COLLATZ_N_DEFAULT
) (
  input  logic [N-1:0] value,
  output logic [N-1:0] next_value,
  output logic [1:0]   count_inc,
  output logic         ovf
);

  logic [N+1:0] wide;
  logic [N+1:0] triple;

  // 3*value+1 is formed two bits wider than the data so the overflow is
  // visible in the top bits instead of silently wrapping.  The overflow test
  // always uses the unshifted product, even in the shortcut build.
  always_comb begin
    wide       = {2'b00, value};
    triple     = (wide << 1) + wide + {{(N+1){1'b0}}, 1'b1};
    next_value = value >> 1;
    count_inc  = 2'd1;
    ovf        = 1'b0;
    if (value[0]) begin
      ovf = |triple[N+1:N];
`ifdef COLLATZ_SHORTCUT_EN
      next_value = triple[N:1];
      count_inc  = 2'd2;
`else
      next_value = triple[N-1:0];
`endif
    end
  end

endmodule

// File: rtl/collatz_responder.sv
// ---------------------------------------------------------------------------
// collatz_responder
//   Accepts a starting value n on a req/ack channel, iterates the Collatz map
//   one update per cycle and returns the number of steps to reach 1 on a
//   valid/ready channel.
//   Ports:
//     clk      in   1  rising-edge clock
//     rst_n    in   1  synchronous active-low reset
//     a_data   in   N  starting value n
//     a_req    in   1  request valid, held until a_ack
//     a_ack    out  1  one-cycle registered accept pulse
//     b_data   out  N  step count (all ones when b_ovf)
//     b_ovf    out  1  intermediate value or step count overflowed N bits
//     b_valid  out  1  result valid, held until b_ready
//     b_ready  in   1  consumer accepts result
//   Configuration macro: COLLATZ_SHORTCUT_EN (selects the shortcut odd update
//   inside collatz_step; results are identical, only latency changes).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module collatz_responder
  import collatz_responder_pkg::*;
#(
  parameter int N = COLLATZ_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a_data,
  input  logic         a_req,
  output logic         a_ack,
  output logic [N-1:0] b_data,
  output logic         b_ovf,
  output logic         b_valid,
  input  logic         b_ready
);

  localparam logic [N-1:0] ALL_ONES = ALL_ONES_WIDE[N-1:0];

  state_t       state, state_next;
  logic [N-1:0] value, value_next;
  logic [N-1:0] count, count_next;
  logic         ack_next;
  logic         valid_next;
  logic [N-1:0] data_next;
  logic         ovf_next;

  logic [N-1:0] step_value;
  logic [1:0]   step_inc;
  logic         step_ovf;
  logic [N:0]   count_sum;

  collatz_step #(.N(N)) u_step (
    .value      (value),
    .next_value (step_value),
    .count_inc  (step_inc),
    .ovf        (step_ovf)
  );

  // State register plus the datapath and output registers.  Every output is
  // a flop, so there is no combinational path from a_req or b_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      value   <= '0;
      count   <= '0;
      a_ack   <= 1'b0;
      b_valid <= 1'b0;
      b_data  <= '0;
      b_ovf   <= 1'b0;
    end else begin
      state   <= state_next;
      value   <= value_next;
      count   <= count_next;
      a_ack   <= ack_next;
      b_valid <= valid_next;
      b_data  <= data_next;
      b_ovf   <= ovf_next;
    end
  end

  // Next-state and next-output logic.  The step count is widened by one bit
  // so that a shortcut +2 cannot jump past the all-ones limit unnoticed; the
  // all-ones count is reserved as the invalid-result code.  Result registers
  // are cleared on leaving DONE so b_data/b_ovf read 0 while b_valid is low.
  always_comb begin
    state_next = state;
    value_next = value;
    count_next = count;
    ack_next   = 1'b0;
    valid_next = b_valid;
    data_next  = b_data;
    ovf_next   = b_ovf;
    count_sum  = {1'b0, count} + {{(N-1){1'b0}}, step_inc};

    case (state)
      IDLE: begin
        if (a_req) begin
          value_next = a_data;
          count_next = '0;
          ack_next   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (value <= {{(N-1){1'b0}}, 1'b1}) begin
          state_next = DONE;
          valid_next = 1'b1;
          data_next  = count;
          ovf_next   = 1'b0;
        end else if (step_ovf || (count_sum >= {1'b0, ALL_ONES})) begin
          state_next = DONE;
          valid_next = 1'b1;
          data_next  = ALL_ONES;
          ovf_next   = 1'b1;
        end else begin
          value_next = step_value;
          count_next = count_sum[N-1:0];
        end
      end
      DONE: begin
        if (b_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
          data_next  = '0;
          ovf_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        data_next  = '0;
        ovf_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_collatz_responder.sv
// ---------------------------------------------------------------------------
// tb_collatz_responder
//   Scoreboard bench for collatz_responder.  Stimulus pushes the expected
//   result (and its expected first-valid cycle) when a request is acked; a
//   separate monitor pops and compares whenever b_valid rises.  A second
//   instance with N=8 covers the overflow path.
//   Build with +define+COLLATZ_SHORTCUT_EN to exercise the shortcut build;
//   expected step counts are identical, only the latency model changes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_collatz_responder;

  localparam int N = 27;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a_data;
  logic         a_req;
  logic         a_ack;
  logic [N-1:0] b_data;
  logic         b_ovf;
  logic         b_valid;
  logic         b_ready;

  logic [7:0]   a8_data;
  logic         a8_req;
  logic         a8_ack;
  logic [7:0]   b8_data;
  logic         b8_ovf;
  logic         b8_valid;
  logic         b8_ready;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit mon_on       = 1'b0;

  typedef struct {
    logic [N-1:0] data;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];

  logic         prev_valid = 1'b0;
  logic [N-1:0] held_data;
  logic         held_ovf;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  collatz_responder #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_data  (a_data),
    .a_req   (a_req),
    .a_ack   (a_ack),
    .b_data  (b_data),
    .b_ovf   (b_ovf),
    .b_valid (b_valid),
    .b_ready (b_ready)
  );

  collatz_responder #(.N(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_data  (a8_data),
    .a_req   (a8_req),
    .a_ack   (a8_ack),
    .b_data  (b8_data),
    .b_ovf   (b8_ovf),
    .b_valid (b8_valid),
    .b_ready (b8_ready)
  );

  // One comparison: counts it, reports a failure with both values.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Number of RUN update cycles for the shortcut build.
  function automatic int stepsShort(input int n);
    int v;
    int s;
    v = n;
    s = 0;
    while (v > 1) begin
      if (v % 2 == 0) v = v / 2;
      else            v = (3 * v + 1) / 2;
      s++;
    end
    return s;
  endfunction

  // In the plain build every update is one step, so S equals the step count.
  function automatic int latencySteps(input int n, input int exp_steps);
`ifdef COLLATZ_SHORTCUT_EN
    return stepsShort(n);
`else
    return exp_steps + 0 * n;
`endif
  endfunction

  // Raise a request, wait for its ack, optionally register the expectation.
  task automatic applyStimulus(input logic [N-1:0] n, input logic [N-1:0] exp_data,
                               input logic exp_ovf, input bit track);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    a_data = n;
    a_req  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_ack) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("a_ack for n=%0d", n), {63'd0, got}, 64'd1);
    if (got && track)
      sb.push_back('{data: exp_data, ovf: exp_ovf,
                     due: cyc + latencySteps(int'(n), int'(exp_data)) + 1});
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("a_ack single pulse n=%0d", n), {63'd0, a_ack}, 64'd0);
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !b_valid) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("result drained in time", {63'd0, done}, 64'd1);
  endtask

  task automatic run8(input logic [7:0] n, input logic [7:0] exp_data, input logic exp_ovf);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    a8_data = n;
    a8_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a8_ack) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    a8_req = 1'b0;
    checkOutput($sformatf("N8 a_ack n=%0d", n), {63'd0, got}, 64'd1);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b8_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("N8 b_valid n=%0d", n), {63'd0, got}, 64'd1);
    checkOutput($sformatf("N8 b_ovf n=%0d", n), {63'd0, b8_ovf}, {63'd0, exp_ovf});
    checkOutput($sformatf("N8 b_data n=%0d", n), {56'd0, b8_data}, {56'd0, exp_data});
    @(negedge clk);
    checkOutput($sformatf("N8 b_valid released n=%0d", n), {63'd0, b8_valid}, 64'd0);
  endtask

  // Monitor: compares each result as it appears, checks it stays stable
  // while held, and checks the result lines are zero whenever b_valid is low.
  always @(negedge clk) begin
    if (mon_on) begin
      if (b_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected result presented", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("b_data", {37'd0, b_data}, {37'd0, e.data});
          checkOutput("b_ovf", {63'd0, b_ovf}, {63'd0, e.ovf});
          checkOutput("b_valid latency cycle", 64'(cyc), 64'(e.due));
        end
        held_data = b_data;
        held_ovf  = b_ovf;
      end else if (b_valid && prev_valid) begin
        checkOutput("b_data stable", {37'd0, b_data}, {37'd0, held_data});
        checkOutput("b_ovf stable", {63'd0, b_ovf}, {63'd0, held_ovf});
      end else if (!b_valid) begin
        checkOutput("result zero while invalid", {36'd0, b_ovf, b_data}, 64'd0);
      end
      prev_valid = b_valid;
    end
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int n;
    int steps;
  } vec_t;

  vec_t vecs[8] = '{
    '{6, 8}, '{27, 111}, '{1, 0}, '{0, 0},
    '{7, 16}, '{3, 7}, '{2, 1}, '{97, 118}
  };

  initial begin
    bit got;
    rst_n    = 1'b0;
    a_req    = 1'b0;
    a_data   = '0;
    b_ready  = 1'b1;
    a8_req   = 1'b0;
    a8_data  = '0;
    b8_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset a_ack", {63'd0, a_ack}, 64'd0);
    checkOutput("reset b_valid", {63'd0, b_valid}, 64'd0);
    checkOutput("reset b_data", {37'd0, b_data}, 64'd0);
    checkOutput("reset b_ovf", {63'd0, b_ovf}, 64'd0);
    checkOutput("reset N8 b_valid", {63'd0, b8_valid}, 64'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Directed step counts, including n=0 and n=1
    foreach (vecs[i]) begin
      applyStimulus(N'(vecs[i].n), N'(vecs[i].steps), 1'b0, 1'b1);
      waitIdle();
    end

    // Back-pressure in DONE with a pending request
    @(posedge clk); #1;
    b_ready = 1'b0;
    applyStimulus(27'd6, 27'd8, 1'b0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("b_valid reached before hold", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    a_data = 27'd3;
    a_req  = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkOutput("a_ack blocked in DONE", {63'd0, a_ack}, 64'd0);
      checkOutput("b_valid held in DONE", {63'd0, b_valid}, 64'd1);
    end
    @(posedge clk); #1;
    b_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("no ack on IDLE return cycle", {63'd0, a_ack}, 64'd0);
    checkOutput("b_valid dropped after handshake", {63'd0, b_valid}, 64'd0);
    @(negedge clk);
    checkOutput("ack one cycle after IDLE return", {63'd0, a_ack}, 64'd1);
    if (a_ack)
      sb.push_back('{data: 27'd7, ovf: 1'b0, due: cyc + latencySteps(3, 7) + 1});
    @(posedge clk); #1;
    a_req = 1'b0;
    waitIdle();

    // Reset in the middle of a long computation
    applyStimulus(27'd27, 27'd111, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid-run reset b_valid", {63'd0, b_valid}, 64'd0);
    checkOutput("mid-run reset a_ack", {63'd0, a_ack}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (150) @(posedge clk);
    applyStimulus(27'd7, 27'd16, 1'b0, 1'b1);
    waitIdle();

    // Narrow instance: overflow and a normal result
    run8(8'd27, 8'hFF, 1'b1);
    run8(8'd6, 8'd8, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
